// File: rtl/clock_decrement_if.sv
// Count bus for clock_decrement: requested start value in, current count out.
interface clock_decrement_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] count_input;
  logic [WIDTH-1:0] count_output;

  // Producer of the start value, consumer polling the count
  modport master (
    output count_input,
    input  count_output
  );

  // The countdown timer itself
  modport slave (
    input  count_input,
    output count_output
  );
endinterface

// File: rtl/clock_decrement.sv
// Loadable, self-timed down-counter. A changed count_input reloads the count;
// otherwise the count decrements once per clock and saturates at zero.
module clock_decrement #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_decrement_if.slave     bus
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_last_in;
  logic [WIDTH-1:0] w_cnt_d;
  logic [WIDTH-1:0] w_last_in_d;
  logic             w_load;

  assign w_load = (bus.count_input != r_last_in);

  // Next-state: load on a changed input, else decrement, else hold at zero
  always_comb begin
    w_cnt_d     = r_cnt;
    w_last_in_d = r_last_in;
    if (w_load) begin
      w_cnt_d     = bus.count_input;
      w_last_in_d = bus.count_input;
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - WIDTH'(1);
    end
  end

  // State registers; async reset clears both the count and the load shadow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_last_in <= '0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_last_in <= w_last_in_d;
    end
  end

  assign bus.count_output = r_cnt;

endmodule

// File: tb/tb_clock_decrement.sv
// Scoreboard bench for clock_decrement: stimulus pushes the count expected
// after each rising edge; a monitor pops and compares just after that edge.
module tb_clock_decrement;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [WIDTH-1:0] exp_q[$];

  clock_decrement_if #(.WIDTH(WIDTH)) bus ();

  clock_decrement #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive the input, record the count expected after the
  // coming rising edge, then move on to the following negedge.
  task automatic step(input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] exp);
    bus.count_input = val;
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  // Monitor: the count is presented every cycle; compare whenever one is due
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", bus.count_output, e);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.count_input = 16'hABC1;
    #1 rst = 1'b0;
    #1 check("reset_immediate", bus.count_output, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", bus.count_output, 16'h0000);
    end

    // Release with a load of 1: 1, then 0, then hold
    rst = 1'b1;
    step(16'h0001, 16'h0001);
    step(16'h0001, 16'h0000);
    for (int i = 0; i < 10; i++) step(16'h0001, 16'h0000);

    // Reload mid-count
    step(16'hABC1, 16'hABC1);
    step(16'hABC1, 16'hABC0);
    step(16'hABC1, 16'hABBF);
    step(16'hABC1, 16'hABBE);
    step(16'hFFAA, 16'hFFAA);
    step(16'hFFAA, 16'hFFA9);

    // Saturation at zero, never wrapping
    step(16'h0003, 16'h0003);
    step(16'h0003, 16'h0002);
    step(16'h0003, 16'h0001);
    step(16'h0003, 16'h0000);
    step(16'h0003, 16'h0000);
    step(16'h0003, 16'h0000);

    // Same value does not reload; a different value in between does
    step(16'h0003, 16'h0000);
    step(16'h0003, 16'h0000);
    step(16'h0004, 16'h0004);
    step(16'h0003, 16'h0003);
    step(16'h0003, 16'h0002);

    // Loading zero from nonzero last value
    step(16'h0000, 16'h0000);
    step(16'h0000, 16'h0000);

    // Async reset mid-count
    step(16'hCEAB, 16'hCEAB);
    step(16'hCEAB, 16'hCEAA);
    step(16'hCEAB, 16'hCEA9);
    step(16'hCEAB, 16'hCEA8);
    step(16'hCEAB, 16'hCEA7);
    step(16'hCEAB, 16'hCEA6);
    #2 rst = 1'b0;
    #1 check("async_reset", bus.count_output, 16'h0000);
    @(posedge clk);
    #1 check("async_reset_hold", bus.count_output, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    step(16'hCEAB, 16'hCEAB);
    step(16'hCEAB, 16'hCEAA);

    // A glitch between edges has no effect; only the edge value counts
    bus.count_input = 16'h9999;
    #2 bus.count_input = 16'hCEAB;
    step(16'hCEAB, 16'hCEA9);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
